// File: rtl/wb_clk_div_ctrl.sv
// Wishbone-programmable clock divider: NUM_CH independent glitch-free divided clocks.
// Ratio changes and stops only take effect at half-period boundaries.
module wb_clk_div_ctrl #(
  parameter int               NUM_CH  = 4,
  parameter int               DIV_W   = 16,
  parameter logic [DIV_W-1:0] DIV_RST = '0
) (
  input  logic              WB_CLK,
  input  logic              WB_RST_N,
  input  logic [4:0]        WBs_ADR,
  input  logic              WBs_CYC,
  input  logic              WBs_STB,
  input  logic              WBs_WE,
  input  logic [3:0]        WBs_BYTE_STB,
  input  logic [31:0]       WBs_WR_DAT,
  output logic [31:0]       WBs_RD_DAT,
  output logic              WBs_ACK,
  output logic [NUM_CH-1:0] Clk_Div_Out,
  output logic [NUM_CH-1:0] Clk_Div_Tick
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} ch_state_t;

  logic                          ack_q, ack_d;
  logic [31:0]                   rd_dat_q, rd_dat_d;
  logic [NUM_CH-1:0]             ctrl_q, ctrl_d;
  logic [NUM_CH-1:0]             pend_q, pend_d;
  logic [NUM_CH-1:0]             out_q, out_d;
  logic [NUM_CH-1:0]             tick_q, tick_d;
  logic [NUM_CH-1:0][DIV_W-1:0]  div_q, div_d;
  logic [NUM_CH-1:0][DIV_W-1:0]  cnt_q, cnt_d;
  ch_state_t                     state_q [NUM_CH];
  ch_state_t                     state_d [NUM_CH];

  logic              bus_req, bus_wr, bus_rd;
  logic [NUM_CH-1:0] run, div_wr, reload;
  logic              unused_bus;

  // Upper write-data bits and lanes beyond the register widths are intentionally ignored.
  assign unused_bus = ^{WBs_WR_DAT, WBs_BYTE_STB};

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) run[i] = (state_q[i] != ST_IDLE);

    bus_req  = WBs_CYC & WBs_STB & ~ack_q;
    bus_wr   = bus_req & WBs_WE;
    bus_rd   = bus_req & ~WBs_WE;
    ack_d    = bus_req;
    rd_dat_d = '0;
    ctrl_d   = ctrl_q;
    div_d    = div_q;
    div_wr   = '0;

    if (bus_wr && WBs_ADR == 5'd0 && WBs_BYTE_STB[0]) ctrl_d = WBs_WR_DAT[NUM_CH-1:0];

    for (int i = 0; i < NUM_CH; i++) begin
      if (bus_wr && WBs_ADR == 5'(i + 2)) begin
        div_wr[i] = 1'b1;
        for (int b = 0; b < DIV_W; b++) begin
          if (WBs_BYTE_STB[b/8]) div_d[i][b] = WBs_WR_DAT[b];
        end
      end
    end

    if (bus_rd) begin
      if (WBs_ADR == 5'd0) begin
        rd_dat_d[NUM_CH-1:0] = ctrl_q;
      end else if (WBs_ADR == 5'd1) begin
        rd_dat_d[NUM_CH-1:0]    = run;
        rd_dat_d[16 +: NUM_CH]  = pend_q;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (WBs_ADR == 5'(i + 2)) rd_dat_d[DIV_W-1:0] = div_q[i];
      end
    end
  end

  // Per-channel counter/FSM. Reload always samples the pre-write shadow value, so a
  // bus write landing on a reload cycle leaves PEND set for the next boundary.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]   = cnt_q[i];
      out_d[i]   = out_q[i];
      tick_d[i]  = 1'b0;
      state_d[i] = state_q[i];
      reload[i]  = 1'b0;

      case (state_q[i])
        ST_IDLE: begin
          out_d[i] = 1'b0;
          cnt_d[i] = '0;
          if (ctrl_q[i]) begin
            cnt_d[i]   = div_q[i];
            reload[i]  = 1'b1;
            state_d[i] = ST_RUN;
          end
        end
        ST_RUN, ST_STOP: begin
          if (state_q[i] == ST_RUN || ctrl_q[i]) begin
            if (cnt_q[i] == '0) begin
              out_d[i]  = ~out_q[i];
              tick_d[i] = ~out_q[i];
              cnt_d[i]  = div_q[i];
              reload[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - DIV_W'(1);
            end
            state_d[i] = ctrl_q[i] ? ST_RUN : ST_STOP;
          end else if (!out_q[i]) begin
            cnt_d[i]   = '0;
            state_d[i] = ST_IDLE;
          end else if (cnt_q[i] == '0) begin
            out_d[i]   = 1'b0;
            state_d[i] = ST_IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] - DIV_W'(1);
          end
        end
        default: begin
          out_d[i]   = 1'b0;
          cnt_d[i]   = '0;
          state_d[i] = ST_IDLE;
        end
      endcase

      pend_d[i] = (pend_q[i] & ~reload[i]) | div_wr[i];
    end
  end

  always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
    if (!WB_RST_N) begin
      ack_q    <= 1'b0;
      rd_dat_q <= '0;
      ctrl_q   <= '0;
      pend_q   <= '0;
      out_q    <= '0;
      tick_q   <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= DIV_RST;
        state_q[i] <= ST_IDLE;
      end
    end else begin
      ack_q    <= ack_d;
      rd_dat_q <= rd_dat_d;
      ctrl_q   <= ctrl_d;
      pend_q   <= pend_d;
      out_q    <= out_d;
      tick_q   <= tick_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      for (int i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
    end
  end

  assign WBs_ACK      = ack_q;
  assign WBs_RD_DAT   = rd_dat_q;
  assign Clk_Div_Out  = out_q;
  assign Clk_Div_Tick = tick_q;

endmodule
